// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the default watchdog limit.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, plus
// lane selection and sign/zero extension of load data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be        = 4'b1111;
    wdata     = wd;
    load_data = rdata;
    lane_b    = rdata[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{wd[7:0]}};
        load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{wd[15:0]}};
        load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      end
      SIZE_W: begin
        be        = 4'b1111;
        wdata     = wd;
        load_data = rdata;
      end
      default: begin
        be        = 4'b1111;
        wdata     = wd;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack handshake to data memory with pipeline stall.
// Optional watchdog abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic [4:0]  write_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        misalign,
  output logic        bus_error
);

  logic [0:0]  state;
  logic        mem_op;
  logic        bad_align;
  logic        accept;
  logic        busy;
  logic        timeout;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  mem_lane_align u_align (
    .size        (mem_size),
    .is_unsigned (mem_unsigned),
    .addr_lo     (alu_result_in[1:0]),
    .wd          (write_data_in),
    .rdata       (dmem_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .load_data   (load_data)
  );

  assign mem_op    = in_valid & (mem_read | mem_write);
  assign bad_align = ((mem_size == SIZE_H) & alu_result_in[0]) |
                     (mem_size[1] & (alu_result_in[1:0] != 2'b00));
  assign busy      = (state == ST_BUSY);
  assign accept    = ~busy & mem_op & ~bad_align;

  // Watchdog: counts BUSY cycles without ack, aborts at TIMEOUT_CYCLES-1.
`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (busy & ~dmem_ack) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = busy & ~dmem_ack & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  // Request stage: fields latched on acceptance and held until ack/abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else if (accept) begin
      state      <= ST_BUSY;
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {alu_result_in[31:2], 2'b00};
      dmem_be    <= lane_be;
      dmem_wdata <= lane_wdata;
    end else if (busy & (dmem_ack | timeout)) begin
      state    <= ST_IDLE;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end
  end

  // Completion stage: stall, load return and WB control.
  assign stall     = ~rst & (busy ? ~(dmem_ack | timeout) : accept);
  assign misalign  = ~rst & ~busy & mem_op & bad_align;
  assign bus_error = timeout;

  assign read_data_out  = (busy & dmem_ack & ~mem_write) ? load_data : 32'h0;
  assign alu_result_out = alu_result_in;
  assign write_reg_out  = write_reg_in;
  assign MemtoReg_out   = MemtoReg_in;
  assign RegWrite_out   = RegWrite_in & ~misalign & ~bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases plus random loads/stores
// against a behavioural lane/extension model. Define MEM_TIMEOUT_EN for the watchdog case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_result_in, write_data_in;
  logic        RegWrite_in, MemtoReg_in;
  logic [4:0]  write_reg_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, RegWrite_out, MemtoReg_out, misalign, bus_error;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .write_reg_in(write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .misalign(misalign), .bus_error(bus_error)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz >= 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << (a % 4));
    if (sz == 2'b01) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wdv);
    if (sz == 2'b00) return (wdv & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wdv & 32'hFFFF) * 32'h0001_0001;
    return wdv;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rdv);
    logic [31:0] sh, v;
    sh = rdv >> (8 * (a % 4));
    if (sz == 2'b00) begin
      v = sh & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = sh & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdv;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
    dmem_ack = 0;
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wdv, input logic [31:0] rdv,
                        input int dly, input logic iv);
    logic mem, mis;
    logic [4:0] wreg;
    mem  = iv & (rd | wr);
    mis  = is_misaligned(sz, a);
    wreg = 5'($urandom);
    @(posedge clk); #1;
    in_valid = iv; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result_in = a; write_data_in = wdv; RegWrite_in = 1'b1; MemtoReg_in = rd;
    write_reg_in = wreg; dmem_ack = 0; dmem_rdata = $urandom;
    @(negedge clk);
    check_val("alu_pass", alu_result_out, a);
    check_val("wreg_pass", 32'(write_reg_out), 32'(wreg));
    check_val("m2r_pass", 32'(MemtoReg_out), 32'(rd));
    if (!mem) begin
      check_val("nop_stall", 32'(stall), 0);
      check_val("nop_rdata", read_data_out, 0);
      check_val("nop_regwr", 32'(RegWrite_out), 1);
      check_val("nop_mis", 32'(misalign), 0);
    end else if (mis) begin
      check_val("mis_pulse", 32'(misalign), 1);
      check_val("mis_stall", 32'(stall), 0);
      check_val("mis_regwr", 32'(RegWrite_out), 0);
    end else begin
      check_val("req_stall", 32'(stall), 1);
      check_val("req_mis", 32'(misalign), 0);
      check_val("req_pre", 32'(dmem_req), 0);
      for (int k = 0; k <= dly; k++) begin
        @(posedge clk); #1;
        dmem_ack   = (k == dly);
        dmem_rdata = (k == dly) ? rdv : $urandom;
        @(negedge clk);
        check_val("busy_req", 32'(dmem_req), 1);
        check_val("busy_we", 32'(dmem_we), 32'(wr));
        check_val("busy_addr", dmem_addr, a & 32'hFFFF_FFFC);
        check_val("busy_be", 32'(dmem_be), 32'(model_be(sz, a)));
        if (wr) check_val("busy_wdata", dmem_wdata, model_wdata(sz, wdv));
        check_val("busy_stall", 32'(stall), (k == dly) ? 0 : 1);
        check_val("busy_berr", 32'(bus_error), 0);
        if (k == dly && !wr) check_val("load_data", read_data_out, model_load(sz, uns, a, rdv));
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_val("post_req", 32'(dmem_req), 0);
    check_val("post_stall", 32'(stall), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    alu_result_in = 32'h100; write_data_in = 0; RegWrite_in = 1; MemtoReg_in = 0;
    write_reg_in = 0; dmem_rdata = 0;
    in_valid = 1; mem_read = 1; mem_size = 2'b10;
    repeat (2) @(negedge clk);
    check_val("rst_req", 32'(dmem_req), 0);
    check_val("rst_we", 32'(dmem_we), 0);
    check_val("rst_be", 32'(dmem_be), 0);
    check_val("rst_addr", dmem_addr, 0);
    check_val("rst_wdata", dmem_wdata, 0);
    check_val("rst_stall", 32'(stall), 0);
    check_val("rst_mis", 32'(misalign), 0);
    check_val("rst_berr", 32'(bus_error), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    run_op(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEAD_BEEF, 3, 1);
    run_op(0, 1, 2'b00, 0, 32'h203, 32'h0000_00A5, 0, 0, 1);
    run_op(1, 0, 2'b01, 0, 32'h302, 0, 32'h8001_1234, 1, 1);
    run_op(1, 0, 2'b01, 1, 32'h302, 0, 32'h8001_1234, 0, 1);
    run_op(1, 0, 2'b00, 0, 32'h301, 0, 32'h8001_1234, 2, 1);
    run_op(1, 0, 2'b10, 0, 32'h102, 0, 0, 0, 1);
    run_op(1, 1, 2'b11, 0, 32'h40, 32'h1234_5678, 0, 0, 1);

    // Async reset in the second BUSY cycle aborts the access.
    @(posedge clk); #1;
    in_valid = 1; mem_read = 1; mem_write = 0; mem_size = 2'b10; alu_result_in = 32'h100;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_val("arst_req", 32'(dmem_req), 0);
    check_val("arst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_val("arst_idle", 32'(dmem_req), 0);
    run_op(1, 0, 2'b10, 0, 32'h100, 0, 32'hCAFE_F00D, 1, 1);

`ifdef MEM_TIMEOUT_EN
    @(posedge clk); #1;
    in_valid = 1; mem_read = 1; mem_write = 0; mem_size = 2'b10; alu_result_in = 32'h180;
    RegWrite_in = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("wd_berr", 32'(bus_error), (k == 8) ? 1 : 0);
      check_val("wd_stall", 32'(stall), (k == 8) ? 0 : 1);
      if (k == 8) begin
        check_val("wd_regwr", 32'(RegWrite_out), 0);
        check_val("wd_rdata", read_data_out, 0);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_val("wd_req", 32'(dmem_req), 0);
    check_val("wd_berr_off", 32'(bus_error), 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic rd, wr, iv;
      logic [31:0] a;
      rd = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0) ? 1'b1 : ~rd;
      iv = ($urandom_range(0, 7) != 0);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'(2'($urandom) & 2'b10);
      run_op(rd, wr, 2'($urandom), 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), iv);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
